// File: rtl/pixel_raster_transfer_if.sv
// Signal bundle between the raster read engine, the image ROM and the downstream masking logic.
// The master side is the engine; the slave side is ROM plus pixel consumer.
interface pixel_raster_transfer_if #(
    parameter int PIX_W = 12,
    parameter int ROW_W = 8,
    parameter int COL_W = 9
);
    logic [PIX_W-1:0] rom_pixel;
    logic [ROW_W-1:0] rom_pix_row;
    logic [COL_W-1:0] rom_pix_col;
    logic [PIX_W-1:0] pixel_out;
    logic [ROW_W-1:0] pix_row;
    logic [COL_W-1:0] pix_col;
    logic             pix_valid;
    logic             frame_end;

    modport master (
        input  rom_pixel,
        output rom_pix_row, rom_pix_col,
        output pixel_out, pix_row, pix_col, pix_valid, frame_end
    );

    modport slave (
        output rom_pixel,
        input  rom_pix_row, rom_pix_col,
        input  pixel_out, pix_row, pix_col, pix_valid, frame_end
    );
endinterface

// File: rtl/pixel_raster_transfer.sv
// Raster-scan read engine: walks an asynchronous image ROM one pixel per clock and
// emits each colour registered together with the coordinates it was read from.
module pixel_raster_transfer #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int PIX_W = 12,
    parameter int ROW_W = 8,
    parameter int COL_W = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pixel_raster_transfer_if.master io_bus
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [ROW_W-1:0] r_scan_row;
    logic [COL_W-1:0] r_scan_col;
    logic [PIX_W-1:0] r_pixel_out;
    logic [ROW_W-1:0] r_pix_row;
    logic [COL_W-1:0] r_pix_col;
    logic             r_pix_valid;
    logic             r_frame_end;

    logic w_col_last;
    logic w_row_last;

    assign w_col_last = (r_scan_col == COL_LAST);
    assign w_row_last = (r_scan_row == ROW_LAST);

    // ROM address comes straight off the counters so the returned colour lines up
    // with the coordinates captured on the same edge.
    assign io_bus.rom_pix_row = r_scan_row;
    assign io_bus.rom_pix_col = r_scan_col;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scan_row  <= '0;
            r_scan_col  <= '0;
            r_pixel_out <= '0;
            r_pix_row   <= '0;
            r_pix_col   <= '0;
            r_pix_valid <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values;
            // pix_row/pix_col must capture the address the ROM is answering, not the next one.
            r_pixel_out <= io_bus.rom_pixel;
            r_pix_row   <= r_scan_row;
            r_pix_col   <= r_scan_col;
            r_pix_valid <= 1'b1;
            r_frame_end <= w_row_last && w_col_last;

            if (w_col_last) begin
                r_scan_col <= '0;
                r_scan_row <= w_row_last ? '0 : r_scan_row + ROW_W'(1);
            end else begin
                r_scan_col <= r_scan_col + COL_W'(1);
            end
        end
    end

    assign io_bus.pixel_out = r_pixel_out;
    assign io_bus.pix_row   = r_pix_row;
    assign io_bus.pix_col   = r_pix_col;
    assign io_bus.pix_valid = r_pix_valid;
    assign io_bus.frame_end = r_frame_end;
endmodule

// File: tb/tb_pixel_raster_transfer.sv
// Self-checking bench for pixel_raster_transfer: combinational ROM model, independent
// scan model feeding a scoreboard, directed reset / row-wrap / frame-wrap steps.
module tb_pixel_raster_transfer;
    // Short frame keeps two full frames well inside the cycle budget while keeping
    // the full 320-pixel row and a last row whose low nibble is 0xF.
    localparam int IMG_W = 320;
    localparam int IMG_H = 16;
    localparam int PIX_W = 12;
    localparam int ROW_W = 8;
    localparam int COL_W = 9;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [PIX_W-1:0] pix;
        logic             fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_count = 0;

    int m_row = 0;
    int m_col = 0;
    exp_t sb[$];

    pixel_raster_transfer_if #(.PIX_W(PIX_W), .ROW_W(ROW_W), .COL_W(COL_W)) bus ();

    pixel_raster_transfer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ROW_W(ROW_W), .COL_W(COL_W)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [PIX_W-1:0] pix_model(input int row, input int col);
        logic [ROW_W-1:0] r;
        logic [COL_W-1:0] c;
        r = ROW_W'(row);
        c = COL_W'(col);
        return {r[3:0], c[7:0]};
    endfunction

    assign bus.rom_pixel = {bus.rom_pix_row[3:0], bus.rom_pix_col[7:0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel"}, 32'(bus.pixel_out), 32'h0);
        check({tag, "_row"},   32'(bus.pix_row),   32'h0);
        check({tag, "_col"},   32'(bus.pix_col),   32'h0);
        check({tag, "_valid"}, 32'(bus.pix_valid), 32'h0);
        check({tag, "_fend"},  32'(bus.frame_end), 32'h0);
        check({tag, "_rrow"},  32'(bus.rom_pix_row), 32'h0);
        check({tag, "_rcol"},  32'(bus.rom_pix_col), 32'h0);
    endtask

    // One free-running edge: check the presented address, predict the output, advance the model.
    task automatic step();
        exp_t e;
        exp_t got;
        check("rom_row", 32'(bus.rom_pix_row), 32'(m_row));
        check("rom_col", 32'(bus.rom_pix_col), 32'(m_col));
        e.row = ROW_W'(m_row);
        e.col = COL_W'(m_col);
        e.pix = pix_model(m_row, m_col);
        e.fe  = (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
        sb.push_back(e);
        if (m_col == IMG_W - 1) begin
            m_col = 0;
            m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
        @(posedge clk);
        @(negedge clk);
        if (bus.frame_end === 1'b1) fe_count++;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            got = sb.pop_front();
            check("pix_row",   32'(bus.pix_row),   32'(got.row));
            check("pix_col",   32'(bus.pix_col),   32'(got.col));
            check("pixel_out", 32'(bus.pixel_out), 32'(got.pix));
            check("pix_valid", 32'(bus.pix_valid), 32'h1);
            check("frame_end", 32'(bus.frame_end), 32'(got.fe));
            check("rom_match", 32'(bus.pixel_out), 32'(pix_model(int'(bus.pix_row), int'(bus.pix_col))));
        end
    endtask

    task automatic reset_edge(input string tag);
        rst = 1'b1;
        sb.delete();
        m_row = 0;
        m_col = 0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero(tag);
    endtask

    initial begin
        @(negedge clk);
        reset_edge("rst1");
        reset_edge("rst2");
        rst = 1'b0;

        // First three pixels after reset release.
        step();
        check("first_pixel", 32'(bus.pixel_out), 32'h000);
        check("first_valid", 32'(bus.pix_valid), 32'h1);
        step();
        check("second_pixel", 32'(bus.pixel_out), 32'h001);
        step();
        check("third_pixel", 32'(bus.pixel_out), 32'h002);

        // End of row 0 and wrap into row 1.
        while (!(m_row == 0 && m_col == 0 && bus.pix_col == COL_W'(IMG_W - 1))) begin
            step();
            if (m_row > 0) break;
        end
        check("row_end_col",   32'(bus.pix_col),   32'd319);
        check("row_end_pixel", 32'(bus.pixel_out), 32'h03F);
        check("row_wrap_rrow", 32'(bus.rom_pix_row), 32'd1);
        check("row_wrap_rcol", 32'(bus.rom_pix_col), 32'd0);
        step();
        check("row1_row",   32'(bus.pix_row),   32'd1);
        check("row1_col",   32'(bus.pix_col),   32'd0);
        check("row1_pixel", 32'(bus.pixel_out), 32'h100);

        // Run to the end of the first frame.
        while (!(m_row == 0 && m_col == 0)) step();
        check("frame_last_row",   32'(bus.pix_row),   32'(IMG_H - 1));
        check("frame_last_col",   32'(bus.pix_col),   32'(IMG_W - 1));
        check("frame_last_pixel", 32'(bus.pixel_out), 32'hF3F);
        check("frame_end_high",   32'(bus.frame_end), 32'h1);
        step();
        check("wrap_pixel", 32'(bus.pixel_out), 32'h000);
        check("wrap_fend",  32'(bus.frame_end), 32'h0);

        // Mid-frame reset at (9,200): scan abandons the partial frame.
        while (!(m_row == 9 && m_col == 200)) step();
        check("pre_reset_rrow", 32'(bus.rom_pix_row), 32'd9);
        check("pre_reset_rcol", 32'(bus.rom_pix_col), 32'd200);
        reset_edge("midrst");
        rst = 1'b0;
        step();
        check("post_reset_row",   32'(bus.pix_row),   32'd0);
        check("post_reset_col",   32'(bus.pix_col),   32'd0);
        check("post_reset_pixel", 32'(bus.pixel_out), 32'h000);

        // Two consecutive full frames, every output scoreboarded.
        fe_count = 0;
        for (int i = 0; i < 2 * IMG_W * IMG_H; i++) step();
        check("frame_end_count", 32'(fe_count), 32'd2);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pixel_raster_transfer.md
Name: pixel_raster_transfer

Overview:
- Raster-scan read engine for the image masking accelerator.
- Generates (row, col) addresses into an external combinational image ROM, one pixel per clock.
- Registers the returned 12-bit colour together with the coordinates it came from, so downstream masking logic receives a pixel stream tagged with its coordinates.

Parameters:
IMG_W, 320, pixels per row; columns 0..IMG_W-1.
IMG_H, 240, rows per frame; rows 0..IMG_H-1.
PIX_W, 12, colour word width (4:4:4 RGB).
ROW_W, 8, row address width; must satisfy 2^ROW_W >= IMG_H.
COL_W, 9, column address width; must satisfy 2^COL_W >= IMG_W.

Ports:
Clock  in  1  system clock; all state updates on the rising edge.
Reset  in  1  synchronous, active-high reset.
rom_pixel  in  PIX_W  colour data from the image ROM for the current rom_pix_row/rom_pix_col.
rom_pix_row  out  ROW_W  ROM row address; driven directly from the scan row counter.
rom_pix_col  out  COL_W  ROM column address; driven directly from the scan column counter.
pixel_out  out  PIX_W  registered pixel colour.
pix_row  out  ROW_W  registered row of pixel_out.
pix_col  out  COL_W  registered column of pixel_out.
pix_valid  out  1  high when pixel_out/pix_row/pix_col hold a real pixel.
frame_end  out  1  one-cycle pulse when the last pixel of a frame (IMG_H-1, IMG_W-1) is presented.

Behaviour:
- One clock domain (Clock); reset is synchronous and active-high (Reset).
- Scan counters scan_row and scan_col are internal registers.
  - rom_pix_row = scan_row and rom_pix_col = scan_col, with no extra register stage.
- The ROM is asynchronous-read: rom_pixel is valid in the same cycle the address is presented.
- On each rising edge with Reset=0:
  - pixel_out <= rom_pixel
  - pix_row <= scan_row; pix_col <= scan_col
  - pix_valid <= 1
  - frame_end <= (scan_row==IMG_H-1 && scan_col==IMG_W-1)
  - Counters advance in raster order:
    - if scan_col < IMG_W-1: scan_col+1
    - else: scan_col <= 0, and scan_row <= (scan_row==IMG_H-1) ? 0 : scan_row+1
- Latency: a pixel appears on the outputs one edge after its address is presented. pixel_out always matches the ROM content at (pix_row, pix_col); outputs are never misaligned.
- Free-running: one new pixel every cycle, no stalls, no handshake. Frames repeat indefinitely; (IMG_H-1, IMG_W-1) is followed directly by (0, 0).
- Reset (edge with Reset=1):
  - scan_row=0, scan_col=0
  - pixel_out=0, pix_row=0, pix_col=0, pix_valid=0, frame_end=0
  - Applies mid-frame identically: the scan restarts at (0,0) and the partial frame is abandoned.
- During reset the ROM address is (0,0). First edge after reset deasserts presents pixel(0,0), pix_valid=1.
- Counter values never reach IMG_W or IMG_H. Addresses beyond the image are never issued.
- Before the first reset, output values are undefined. The bench must assert Reset first.

Test Plan:
- Bench ROM model: color = {row[3:0], col[7:0]}, combinational.
- Reset held 2 edges -> pixel_out=0, pix_row=0, pix_col=0, pix_valid=0, frame_end=0; rom_pix_row=0, rom_pix_col=0.
- Release reset, 3 edges -> outputs (row,col,pixel) = (0,0,0x000), (0,1,0x001), (0,2,0x002); pix_valid=1 from the first edge.
- Run to end of row 0 -> pixel (0,319, 0x03F) followed by (1,0, 0x100); rom_pix_col wraps 319->0 while rom_pix_row goes 0->1.
- Run a full frame (76800 edges) -> frame_end high exactly in the cycle with pix_row=239, pix_col=319, pixel 0xF3F. Next output is (0,0, 0x000) with frame_end=0.
- Assert Reset at (57,200) for one edge -> all outputs 0 and pix_valid=0. The next edge outputs (0,0, 0x000).
- Every cycle, pixel_out == model(pix_row, pix_col) across two consecutive frames -> zero mismatches. frame_end count = 2.
